// File: rtl/apb_mem_pkg.sv
// Shared types and default parameter values for the APB memory slave.
// The state encoding is common to the slave and any checker that observes it.
package apb_mem_pkg;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_DEPTH       = 64;
    localparam int DEF_WAIT_CYCLES = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/apb_mem_bank.sv
// Byte-strobed word storage with a combinational read port.
// Contents are deliberately not reset so data survives a bus reset.
module apb_mem_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   strb,
    output logic [DATA_W-1:0]     rdata
);

    localparam int LANES = DATA_W / 8;

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Per-lane write: only lanes with their strobe set take new data.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (strb[i]) begin
                    mem_r[idx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem_r[idx];

endmodule

// File: rtl/apb_mem_slave.sv
// APB-style memory slave: FSM with programmable wait states, range checking
// and registered ready/slverr/data_out around a byte-strobed memory bank.
module apb_mem_slave
    import apb_mem_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sel,
    input  logic                  enable,
    input  logic                  w_en,
    input  logic [ADDR_W-1:0]     add,
    input  logic [DATA_W-1:0]     data_in,
    input  logic [DATA_W/8-1:0]   strb,
    output logic                  ready,
    output logic [DATA_W-1:0]     data_out,
    output logic                  slverr
);

    localparam int          STRB_W    = DATA_W / 8;
    localparam int          LSB       = (STRB_W > 1) ? $clog2(STRB_W) : 0;
    localparam int          IDX_W     = ADDR_W - LSB;
    localparam int          BANK_IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);
    localparam logic [31:0] DEPTH_U   = 32'(DEPTH);
    localparam logic        NO_WAIT   = (WAIT_CYCLES == 0);

    state_t              state_r;
    state_t              state_next_s;
    logic [3:0]          cnt_r;
    logic [3:0]          cnt_next_s;
    logic                ready_r;
    logic                slverr_r;
    logic [DATA_W-1:0]   data_out_r;

    logic                access_s;
    logic                xfer_s;
    logic                idx_err_s;
    logic                we_s;
    logic [IDX_W-1:0]    idx_s;
    logic [BANK_IW-1:0]  bank_idx_s;
    logic [DATA_W-1:0]   rdata_s;
    logic                unused_s;

    assign access_s   = sel && enable;
    assign idx_s      = add[ADDR_W-1:LSB];
    assign idx_err_s  = (32'(idx_s) >= DEPTH_U);
    assign bank_idx_s = BANK_IW'(idx_s);
    assign unused_s   = ^{1'b0, add};

    // Next-state and wait counter; dropping sel while waiting aborts the transfer.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (access_s) begin
                    if (NO_WAIT) begin
                        state_next_s = RESP;
                    end else begin
                        state_next_s = WAIT;
                        cnt_next_s   = 4'd1;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (!sel) begin
                    state_next_s = IDLE;
                    cnt_next_s   = 4'd0;
                end else if (enable) begin
                    if (cnt_r == WAIT_LAST) begin
                        state_next_s = RESP;
                        cnt_next_s   = 4'd0;
                    end else begin
                        cnt_next_s = cnt_r + 4'd1;
                    end
                end else begin
                    state_next_s = WAIT;
                end
            end
            RESP: begin
                state_next_s = IDLE;
                cnt_next_s   = 4'd0;
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // The transfer takes effect on the single edge that enters RESP.
    assign xfer_s = (state_next_s == RESP) && (state_r != RESP);
    assign we_s   = xfer_s && w_en && !idx_err_s;

    // State, counter and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            ready_r    <= 1'b0;
            slverr_r   <= 1'b0;
            data_out_r <= {DATA_W{1'b0}};
        end else begin
            state_r  <= state_next_s;
            cnt_r    <= cnt_next_s;
            ready_r  <= xfer_s;
            slverr_r <= xfer_s && idx_err_s;
            if (xfer_s && !w_en && !idx_err_s) begin
                data_out_r <= rdata_s;
            end
        end
    end

    apb_mem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (BANK_IW)
    ) u_bank (
        .clk   (clk),
        .we    (we_s),
        .idx   (bank_idx_s),
        .wdata (data_in),
        .strb  (strb),
        .rdata (rdata_s)
    );

    assign ready    = ready_r;
    assign slverr   = slverr_r;
    assign data_out = data_out_r;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Scoreboard bench for apb_mem_slave: one zero-wait and one 3-wait instance,
// expected responses queued at issue time and checked by a ready-driven monitor.
module tb_apb_mem_slave;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel     [2];
    logic        enable  [2];
    logic        w_en    [2];
    logic [9:0]  add     [2];
    logic [31:0] data_in [2];
    logic [3:0]  strb    [2];
    logic        rdy     [2];
    logic        err     [2];
    logic [31:0] dout    [2];

    exp_t q0[$];
    exp_t q1[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    apb_mem_slave #(.DATA_W(32), .ADDR_W(10), .DEPTH(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sel(sel[0]), .enable(enable[0]), .w_en(w_en[0]),
        .add(add[0]), .data_in(data_in[0]), .strb(strb[0]),
        .ready(rdy[0]), .data_out(dout[0]), .slverr(err[0])
    );

    apb_mem_slave #(.DATA_W(32), .ADDR_W(10), .DEPTH(64), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .sel(sel[1]), .enable(enable[1]), .w_en(w_en[1]),
        .add(add[1]), .data_in(data_in[1]), .strb(strb[1]),
        .ready(rdy[1]), .data_out(dout[1]), .slverr(err[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: pop and compare on every ready pulse; slverr must be low otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (rdy[0] === 1'b1) begin
                if (q0.size() == 0) begin
                    n_total++;
                    $display("FAIL dut0_unexpected_ready: got ready=1, expected no response");
                end else begin
                    e = q0.pop_front();
                    check("dut0_slverr", 32'(err[0]), 32'(e.err));
                    check("dut0_data_out", dout[0], e.data);
                end
            end else begin
                check("dut0_slverr_idle", 32'(err[0]), 32'd0);
            end
            if (rdy[1] === 1'b1) begin
                if (q1.size() == 0) begin
                    n_total++;
                    $display("FAIL dut3_unexpected_ready: got ready=1, expected no response");
                end else begin
                    e = q1.pop_front();
                    check("dut3_slverr", 32'(err[1]), 32'(e.err));
                    check("dut3_data_out", dout[1], e.data);
                end
            end else begin
                check("dut3_slverr_idle", 32'(err[1]), 32'd0);
            end
        end
    end

    task automatic xfer(input int k, input logic we, input logic [9:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic exp_err, input logic [31:0] exp_do,
                        input int exp_lat, input string name);
        exp_t e;
        int   lat;
        e.err  = exp_err;
        e.data = exp_do;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(posedge clk); #1;
        sel[k] = 1'b1; enable[k] = 1'b0; w_en[k] = we;
        add[k] = a; data_in[k] = d; strb[k] = s;
        @(posedge clk); #1;
        enable[k] = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (rdy[k] !== 1'b1 && lat < 40);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        sel[k] = 1'b0; enable[k] = 1'b0;
        @(posedge clk); #1;
        check({name, "_single_pulse"}, 32'(rdy[k]), 32'd0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            sel[k] = 1'b0; enable[k] = 1'b0; w_en[k] = 1'b0;
            add[k] = 10'd0; data_in[k] = 32'd0; strb[k] = 4'd0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready0", 32'(rdy[0]), 32'd0);
        check("reset_dout0", dout[0], 32'd0);
        check("reset_ready3", 32'(rdy[1]), 32'd0);
        check("reset_dout3", dout[1], 32'd0);
        rst_n = 1'b1;

        // Zero-wait instance
        xfer(0, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF, 1'b0, 32'h00000000, 1, "w_beef");
        xfer(0, 1'b0, 10'h010, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF, 1, "r_beef");
        xfer(0, 1'b1, 10'h004, 32'h11223344, 4'hF, 1'b0, 32'hDEADBEEF, 1, "w_1122");
        xfer(0, 1'b1, 10'h004, 32'hAABBCCDD, 4'h5, 1'b0, 32'hDEADBEEF, 1, "w_strb5");
        xfer(0, 1'b0, 10'h004, 32'h0,        4'h0, 1'b0, 32'h11BB33DD, 1, "r_merge");
        xfer(0, 1'b0, 10'h007, 32'h0,        4'h0, 1'b0, 32'h11BB33DD, 1, "r_lowbits");
        xfer(0, 1'b1, 10'h004, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h11BB33DD, 1, "w_strb0");
        xfer(0, 1'b0, 10'h004, 32'h0,        4'h0, 1'b0, 32'h11BB33DD, 1, "r_strb0");
        xfer(0, 1'b1, 10'h000, 32'h01020304, 4'hF, 1'b0, 32'h11BB33DD, 1, "w_idx0");
        xfer(0, 1'b1, 10'h100, 32'h12345678, 4'hF, 1'b1, 32'h11BB33DD, 1, "w_oor");
        xfer(0, 1'b0, 10'h100, 32'h0,        4'h0, 1'b1, 32'h11BB33DD, 1, "r_oor");
        xfer(0, 1'b0, 10'h000, 32'h0,        4'h0, 1'b0, 32'h01020304, 1, "r_idx0");
        xfer(0, 1'b1, 10'h0FC, 32'hCAFEF00D, 4'hF, 1'b0, 32'h01020304, 1, "w_last");
        xfer(0, 1'b0, 10'h0FC, 32'h0,        4'h0, 1'b0, 32'hCAFEF00D, 1, "r_last");

        // Half-asserted handshakes in IDLE must not start a transfer
        @(posedge clk); #1;
        sel[0] = 1'b0; enable[0] = 1'b1; w_en[0] = 1'b1; add[0] = 10'h0FC; strb[0] = 4'hF;
        data_in[0] = 32'h0;
        repeat (3) begin @(posedge clk); #1; check("ignore_en_only", 32'(rdy[0]), 32'd0); end
        sel[0] = 1'b1; enable[0] = 1'b0;
        repeat (3) begin @(posedge clk); #1; check("ignore_sel_only", 32'(rdy[0]), 32'd0); end
        sel[0] = 1'b0; w_en[0] = 1'b0;
        xfer(0, 1'b0, 10'h0FC, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D, 1, "r_after_ignore");

        // Three-wait instance
        xfer(1, 1'b1, 10'h020, 32'h0BADF00D, 4'hF, 1'b0, 32'h00000000, 4, "w3_f00d");
        xfer(1, 1'b0, 10'h020, 32'h0,        4'h0, 1'b0, 32'h0BADF00D, 4, "r3_f00d");

        // Abort a write after two wait edges by dropping sel
        @(posedge clk); #1;
        sel[1] = 1'b1; enable[1] = 1'b0; w_en[1] = 1'b1;
        add[1] = 10'h020; data_in[1] = 32'h55555555; strb[1] = 4'hF;
        @(posedge clk); #1;
        enable[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sel[1] = 1'b0; enable[1] = 1'b0; w_en[1] = 1'b0;
        repeat (6) begin @(posedge clk); #1; check("abort_no_ready", 32'(rdy[1]), 32'd0); end
        xfer(1, 1'b0, 10'h020, 32'h0, 4'h0, 1'b0, 32'h0BADF00D, 4, "r3_after_abort");

        // Asynchronous reset while waiting
        @(posedge clk); #1;
        sel[1] = 1'b1; enable[1] = 1'b0; w_en[1] = 1'b0; add[1] = 10'h020;
        @(posedge clk); #1;
        enable[1] = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ready3", 32'(rdy[1]), 32'd0);
        check("async_rst_slverr3", 32'(err[1]), 32'd0);
        check("async_rst_dout3", dout[1], 32'd0);
        check("async_rst_dout0", dout[0], 32'd0);
        sel[1] = 1'b0; enable[1] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        xfer(1, 1'b0, 10'h020, 32'h0, 4'h0, 1'b0, 32'h0BADF00D, 4, "r3_after_rst");
        xfer(0, 1'b0, 10'h010, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 1, "r0_after_rst");
        xfer(0, 1'b0, 10'h004, 32'h0, 4'h0, 1'b0, 32'h11BB33DD, 1, "r0b_after_rst");

        repeat (3) @(posedge clk);
        #1;
        check("dut0_queue_drained", 32'(q0.size()), 32'd0);
        check("dut3_queue_drained", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/apb_mem_slave.md
APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width in bits (8, 16 or 32).
REQ-002 SHALL have parameter ADDR_W, default 8, byte address width.
REQ-003 SHALL have parameter DEPTH, default 64, number of DATA_W-bit words (at most 2^(ADDR_W-log2(DATA_W/8))).
REQ-004 SHALL have parameter WAIT_CYCLES, default 0, extra wait states per transfer (0..15).
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port sel, input, 1, slave select.
REQ-008 SHALL have port enable, input, 1, access phase.
REQ-009 SHALL have port w_en, input, 1, 1 = write, 0 = read.
REQ-010 SHALL have port add, input, ADDR_W, byte address.
REQ-011 SHALL have port data_in, input, DATA_W, write data.
REQ-012 SHALL have port strb, input, DATA_W/8, byte write strobes.
REQ-013 SHALL have port ready, output, 1, transfer complete; registered.
REQ-014 SHALL have port data_out, output, DATA_W, read data; registered.
REQ-015 SHALL have port slverr, output, 1, transfer error; valid only while ready=1.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 IDLE: on an edge sampling sel&&enable, SHALL go to RESP if WAIT_CYCLES=0, else to WAIT with cnt=1.
REQ-018 WAIT: on an edge sampling sel&&enable, SHALL go to RESP when cnt==WAIT_CYCLES, else cnt+1.
REQ-019 In WAIT, an edge sampling sel=0 SHALL abort to IDLE with no memory update and no ready pulse.
REQ-020 The edge entering RESP SHALL set ready=1 and perform the write or read for that transfer.
REQ-021 ready SHALL therefore rise WAIT_CYCLES+1 edges after the first edge sampling sel&&enable.
REQ-022 RESP SHALL last exactly one cycle, then return to IDLE with ready=0.
REQ-023 enable=1 with sel=0, or sel=1 with enable=0, SHALL be ignored in IDLE.
REQ-024 Word index SHALL be add[ADDR_W-1:log2(DATA_W/8)]; low address bits SHALL be ignored.
REQ-025 If index >= DEPTH, the transfer SHALL complete with slverr=1, no write, and data_out unchanged.
REQ-026 A valid write SHALL update byte lane i only where strb[i]=1; strb=0 SHALL leave the word unchanged with slverr=0.
REQ-027 A valid read SHALL load data_out with mem[index]; data_out SHALL hold until the next valid read.
REQ-028 slverr SHALL be 0 whenever ready=0.
REQ-029 w_en, add, data_in and strb SHALL be sampled on the edge entering RESP.

Reset
REQ-030 Asserting rst_n=0 SHALL immediately force state=IDLE, cnt=0, ready=0, slverr=0, data_out=0, including mid-transfer.
REQ-031 Memory contents SHALL NOT be reset.
REQ-032 The first edge after rst_n rises SHALL be treated as IDLE.

Structure
REQ-033 Package apb_mem_pkg SHALL hold the state enum and default parameter constants.
REQ-034 Byte-strobed storage SHALL be sub-module apb_mem_bank (clk, we, idx, wdata, strb, rdata); the FSM, counter and error logic SHALL be in apb_mem_slave.

Verification
REQ-035 Defaults: write 0xDEADBEEF, strb=0xF, add=0x10; read add=0x10 -> ready high 1 edge after access start, data_out=0xDEADBEEF, slverr=0.
REQ-036 Write 0x11223344 then 0xAABBCCDD with strb=0x5 to add=0x04; read -> data_out=0x11BB33DD.
REQ-037 WAIT_CYCLES=3: read -> ready=0 for 4 access cycles, ready=1 on 5th, single-cycle pulse.
REQ-038 DEPTH=64: write to add=0x100 (index 64, ADDR_W=10) -> slverr=1 with ready; memory and data_out unchanged.
REQ-039 WAIT_CYCLES=3: drop sel after 2 wait edges -> no ready, no write; a following transfer completes normally.
REQ-040 Assert rst_n=0 during WAIT -> ready, slverr and data_out become 0 without a clock edge; earlier written data still reads back.
